// File: rtl/clk_rst_seq_if.sv
// clk_rst_seq_if: 4-phase req/ack/wrn configuration bus for clk_rst_seq.
// Signals:
//   req    master->slave  request, held until ack
//   wrn    master->slave  0 = write, 1 = read
//   add    master->slave  channel register index
//   data   master->slave  write data
//   ack    slave->master  acknowledge, follows req one cycle late
//   r_data slave->master  read data, valid while ack=1
interface clk_rst_seq_if;
    logic        req;
    logic        wrn;
    logic [3:0]  add;
    logic [31:0] data;
    logic        ack;
    logic [31:0] r_data;
    modport master (output req, wrn, add, data, input ack, r_data);
    modport slave (input req, wrn, add, data, output ack, r_data);
endinterface

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: multi-channel reset release sequencer with per-channel clock-enable dividers.
// Ports:
//   clk_i        system clock
//   rstn_i       async active-low pad reset (deassertion synchronised internally)
//   testmode_i   1: rstn_o follows rstn_i, clk_en_o all 1
//   cfg          config bus slave (register k: [DIV_W-1:0]=DIV, [31]=HOLD)
//   clk_en_o     per-channel clock-enable pulse (period DIV+1)
//   rstn_o       per-channel active-low reset
//   init_done_o  1 once every channel slot has been released
module clk_rst_seq #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int REL_GAP     = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              testmode_i,
    clk_rst_seq_if.slave      cfg,
    output logic [NUM_CH-1:0] clk_en_o,
    output logic [NUM_CH-1:0] rstn_o,
    output logic              init_done_o
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int GW = REL_GAP > 1 ? $clog2(REL_GAP) : 1;

    typedef enum logic [1:0] {SYNC, REL, RUN} state_t;

    state_t                   r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic [CW-1:0]            r_ch, w_ch_nxt;
    logic [GW-1:0]            r_gap, w_gap_nxt;
    logic [NUM_CH-1:0]        r_rstn, r_hold, r_clr, w_rel, w_wr, w_en;
    logic [DIV_W-1:0]         r_div [NUM_CH];
    logic [DIV_W-1:0]         r_cnt [NUM_CH];
    logic                     r_ack, w_acc, w_unused;
    logic [31:0]              r_rdata, w_rd;

    // A transaction is accepted only on the first cycle of req, before ack rises.
    assign w_acc    = cfg.req & ~r_ack;
    assign w_unused = ^cfg.data;

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) r_sync <= '0;
        else         r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};

    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_gap_nxt   = r_gap;
        case (r_state)
            SYNC: if (r_sync[SYNC_STAGES-1]) begin
                w_state_nxt = REL;
                w_ch_nxt    = '0;
                w_gap_nxt   = '0;
            end
            // The last channel is released on entering its slot; no trailing gap.
            REL: if (r_ch == CW'(NUM_CH - 1)) w_state_nxt = RUN;
                 else if (r_gap == GW'(REL_GAP - 1)) begin
                     w_ch_nxt  = r_ch + 1'b1;
                     w_gap_nxt = '0;
                 end else w_gap_nxt = r_gap + 1'b1;
            RUN: w_state_nxt = RUN;
            default: w_state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            r_state <= SYNC;
            r_ch    <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_gap   <= w_gap_nxt;
        end

    // Channels whose slot has been reached; HOLD masks them at register time.
    always_comb begin
        w_rel = '0;
        for (int k = 0; k < NUM_CH; k++)
            w_rel[k] = (r_state == RUN) || (r_state == REL && CW'(k) <= r_ch);
    end

    always_comb begin
        w_wr = '0;
        w_rd = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_wr[k] = w_acc & ~cfg.wrn & (cfg.add == 4'(k));
            if (cfg.add == 4'(k)) w_rd = {r_hold[k], 31'(r_div[k])};
        end
    end

    always_comb begin
        w_en = '0;
        for (int k = 0; k < NUM_CH; k++) w_en[k] = r_rstn[k] & (r_cnt[k] == r_div[k]);
    end

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_rstn  <= '0;
            r_hold  <= '0;
            r_clr   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_div[k] <= '0;
                r_cnt[k] <= '0;
            end
        end else begin
            r_ack  <= cfg.req;
            r_rstn <= w_rel & ~r_hold;
            r_clr  <= w_wr;
            if (w_acc & cfg.wrn) r_rdata <= w_rd;
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_wr[k]) begin
                    r_div[k]  <= cfg.data[DIV_W-1:0];
                    r_hold[k] <= cfg.data[31];
                end
                // r_clr restarts the count the cycle after a DIV write.
                r_cnt[k] <= (r_clr[k] | ~r_rstn[k] | w_en[k]) ? '0 : r_cnt[k] + 1'b1;
            end
        end

    assign cfg.ack      = r_ack;
    assign cfg.r_data   = r_rdata;
    assign clk_en_o     = testmode_i ? '1 : w_en;
    assign rstn_o       = testmode_i ? {NUM_CH{rstn_i}} : r_rstn;
    assign init_done_o  = (r_state == RUN);
endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq: scoreboard bench for clk_rst_seq release timing, dividers, holds and config handshake.
module tb_clk_rst_seq;
    localparam int NUM_CH = 4;
    localparam int SYNC_STAGES = 2;
    localparam int GAP = 16;
    localparam int T0 = SYNC_STAGES + 2;

    typedef struct {int ch; int cyc;} ev_t;

    logic              clk, rstn, tm;
    logic [NUM_CH-1:0] clk_en, rstn_o;
    logic              done;
    int                total, bad;
    ev_t               rel_q[$];
    ev_t               en_q[$];
    logic [31:0]       rd_q[$];

    clk_rst_seq_if cfg_if();

    clk_rst_seq #(.NUM_CH(NUM_CH), .DIV_W(8), .SYNC_STAGES(SYNC_STAGES), .REL_GAP(GAP)) dut (
        .clk_i(clk), .rstn_i(rstn), .testmode_i(tm), .cfg(cfg_if),
        .clk_en_o(clk_en), .rstn_o(rstn_o), .init_done_o(done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic cfg_xfer(input logic wrn, input logic [3:0] add, input logic [31:0] data, output int lat);
        int n;
        logic [31:0] e;
        n = 0;
        while (cfg_if.ack && n < 10) begin
            @(negedge clk);
            n++;
        end
        cfg_if.wrn = wrn;
        cfg_if.add = add;
        cfg_if.data = data;
        cfg_if.req = 1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cfg_if.ack && lat < 10);
        total++;
        if (!cfg_if.ack) begin
            bad++;
            $display("FAIL ack_timeout add=%0d: got ack=0 after %0d cycles, required 1", add, lat);
        end else if (wrn && rd_q.size() > 0) begin
            e = rd_q.pop_front();
            total++;
            if (cfg_if.r_data !== e) begin
                bad++;
                $display("FAIL read add=%0d: got %h required %h", add, cfg_if.r_data, e);
            end
        end
        cfg_if.req = 0;
    endtask

    task automatic watch_release(input logic [3:0] skip, input int nmax);
        logic [3:0] prev;
        ev_t e;
        prev = rstn_o;
        for (int n = 1; n <= nmax; n++) begin
            @(negedge clk);
            if (cfg_if.ack) cfg_if.req = 0;
            for (int k = 0; k < NUM_CH; k++) if (rstn_o[k] && !prev[k]) begin
                total++;
                if (rel_q.size() == 0) begin
                    bad++;
                    $display("FAIL rel_extra: got ch%0d at cycle %0d, required no release", k, n);
                end else begin
                    e = rel_q.pop_front();
                    if (e.ch !== k || e.cyc !== n) begin
                        bad++;
                        $display("FAIL rel_timing: got ch%0d@%0d required ch%0d@%0d", k, n, e.ch, e.cyc);
                    end
                end
            end
            if (n == T0 + 3 * GAP - 1) begin
                total++;
                if (done !== 1'b0) begin bad++; $display("FAIL init_early: got %b required 0", done); end
            end
            if (n == T0 + 3 * GAP + 1) begin
                total++;
                if (done !== 1'b1) begin bad++; $display("FAIL init_done: got %b required 1", done); end
            end
            prev = rstn_o;
        end
        total++;
        if (rel_q.size() != 0) begin
            bad++;
            $display("FAIL rel_missing: got %0d pending releases, required 0", rel_q.size());
            rel_q.delete();
        end
        total++;
        if ((rstn_o & skip) !== 4'b0) begin
            bad++;
            $display("FAIL rel_skip: got rstn_o=%b required masked %b low", rstn_o, skip);
        end
    endtask

    task automatic watch_en(input int ch, input int from, input int to);
        ev_t e;
        for (int n = 1; n <= to; n++) begin
            @(negedge clk);
            if (n >= from && clk_en[ch]) begin
                total++;
                if (en_q.size() == 0) begin
                    bad++;
                    $display("FAIL en_extra ch%0d: got pulse at %0d, required none", ch, n);
                end else begin
                    e = en_q.pop_front();
                    if (e.cyc !== n) begin
                        bad++;
                        $display("FAIL en_timing ch%0d: got pulse at %0d required %0d", ch, n, e.cyc);
                    end
                end
            end
        end
        total++;
        if (en_q.size() != 0) begin
            bad++;
            $display("FAIL en_missing ch%0d: got %0d pending pulses, required 0", ch, en_q.size());
            en_q.delete();
        end
    endtask

    task automatic push_power_on(input logic [3:0] skip);
        for (int k = 0; k < NUM_CH; k++) if (!skip[k]) rel_q.push_back('{k, T0 + GAP * k});
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if (rstn_o !== 4'b0 || clk_en !== 4'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: got rstn_o=%b clk_en=%b done=%b required all 0", rstn_o, clk_en, done);
        end
        total++;
        if (cfg_if.ack !== 1'b0 || cfg_if.r_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_cfg: got ack=%b r_data=%h required 0/0", cfg_if.ack, cfg_if.r_data);
        end
    endtask

    task automatic test_power_on;
        @(negedge clk);
        rstn = 1;
        push_power_on(4'b0000);
        watch_release(4'b0000, 60);
    endtask

    task automatic test_divider;
        int lat;
        cfg_xfer(0, 1, 32'h3, lat);
        for (int c = 4; c <= 12; c += 4) en_q.push_back('{1, c});
        watch_en(1, 1, 14);
        cfg_xfer(0, 1, 32'h0, lat);
        for (int c = 1; c <= 8; c++) en_q.push_back('{1, c});
        watch_en(1, 1, 8);
    endtask

    task automatic test_soft_reset;
        int lat;
        cfg_xfer(0, 2, 32'h8000_0000, lat);
        total++;
        if (rstn_o[2] !== 1'b1) begin bad++; $display("FAIL hold_early: got %b required 1", rstn_o[2]); end
        @(negedge clk);
        total++;
        if (rstn_o[2] !== 1'b0 || clk_en[2] !== 1'b0) begin
            bad++;
            $display("FAIL hold_set: got rstn=%b en=%b required 0/0", rstn_o[2], clk_en[2]);
        end
        cfg_xfer(0, 2, 32'h0, lat);
        total++;
        if (rstn_o[2] !== 1'b0) begin bad++; $display("FAIL unhold_early: got %b required 0", rstn_o[2]); end
        @(negedge clk);
        total++;
        if (rstn_o[2] !== 1'b1) begin bad++; $display("FAIL unhold: got %b required 1", rstn_o[2]); end
        rd_q.push_back(32'h0);
        cfg_xfer(1, 2, 32'h0, lat);
    endtask

    task automatic test_handshake;
        int lat;
        cfg_xfer(0, 3, 32'h7FFF_FF5A, lat);
        rd_q.push_back(32'h0000_005A);
        cfg_xfer(1, 3, 32'h0, lat);
        rd_q.push_back(32'h0);
        cfg_xfer(1, 7, 32'h0, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL ack_latency: got %0d required 1", lat); end
        @(negedge clk);
        total++;
        if (cfg_if.ack !== 1'b0) begin bad++; $display("FAIL ack_drop: got %b required 0", cfg_if.ack); end
        cfg_xfer(0, 4, 32'h8000_0000, lat);
        repeat (2) @(negedge clk);
        total++;
        if (rstn_o !== 4'hF) begin bad++; $display("FAIL oob_write: got rstn_o=%b required 1111", rstn_o); end
    endtask

    task automatic test_hold_prerelease;
        int lat;
        @(negedge clk);
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        cfg_if.wrn = 0;
        cfg_if.add = 1;
        cfg_if.data = 32'h8000_0000;
        cfg_if.req = 1;
        push_power_on(4'b0010);
        watch_release(4'b0010, 60);
        total++;
        if (clk_en[1] !== 1'b0) begin bad++; $display("FAIL held_en: got %b required 0", clk_en[1]); end
        cfg_xfer(0, 1, 32'h0, lat);
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        rel_q.push_back('{0, T0});
        rel_q.push_back('{1, T0 + GAP});
        watch_release(4'b0000, T0 + GAP + 4);
        @(negedge clk);
        #2 rstn = 0;
        #1;
        total++;
        if (rstn_o !== 4'b0 || clk_en !== 4'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL async_rst: got rstn_o=%b en=%b done=%b required all 0", rstn_o, clk_en, done);
        end
        test_power_on();
    endtask

    task automatic test_testmode;
        @(negedge clk);
        tm = 1;
        #1;
        total++;
        if (rstn_o !== 4'hF || clk_en !== 4'hF) begin
            bad++;
            $display("FAIL tm_on: got rstn_o=%b en=%b required 1111/1111", rstn_o, clk_en);
        end
        rstn = 0;
        #1;
        total++;
        if (rstn_o !== 4'h0 || clk_en !== 4'hF) begin
            bad++;
            $display("FAIL tm_rst: got rstn_o=%b en=%b required 0000/1111", rstn_o, clk_en);
        end
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        tm = 0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rstn = 0;
        tm = 0;
        cfg_if.req = 0;
        cfg_if.wrn = 0;
        cfg_if.add = 0;
        cfg_if.data = 0;
        test_reset();
        test_power_on();
        test_divider();
        test_soft_reset();
        test_handshake();
        test_hold_prerelease();
        test_async_reset();
        test_testmode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
